// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues word fetches to imem and buffers returned instructions in order for decode.
// Latency: with zero-wait memory a request in cycle N returns in N+1 and shows as inst_valid in N+2 (no bypass).
// Backpressure: inst_ready low fills the buffer; credits (outstanding + buffered <= DEPTH) then hold imem_req low.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcplus4,
  output logic [6:0]      op
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } ibuf_ent_t;

  // Fetch PC and number of in-flight responses that belong to a squashed path
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   discard_q, discard_d;

  // PCs of granted requests, oldest first; occupancy is the outstanding count
  logic [XLEN-1:0] pcq_q [DEPTH];
  logic [AW-1:0]   pq_wr_ptr_q, pq_rd_ptr_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;

  // Instruction buffer presented to decode
  ibuf_ent_t       ibuf_q [DEPTH];
  logic [AW-1:0]   ib_wr_ptr_q, ib_rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic [CW:0]     credits_used;
  logic            grant;
  logic            rsp_take;
  logic            iq_wr;
  logic            iq_pop;
  ibuf_ent_t       head;

  // A stray rvalid with nothing in flight is ignored so counters never underflow.
  assign credits_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req     = !reset && !redirect_valid && (credits_used < {1'b0, FULL});
  assign imem_addr    = fetch_pc_q;
  assign grant        = imem_req && imem_gnt;
  assign rsp_take     = imem_rvalid && (outstanding_q != '0);
  assign iq_wr        = rsp_take && (discard_q == '0) && !redirect_valid;
  assign iq_pop       = inst_valid && inst_ready;

  assign head         = ibuf_q[ib_rd_ptr_q];
  assign inst_valid   = (count_q != '0);
  assign inst         = head.word;
  assign inst_pc      = head.pc;
  assign inst_pcplus4 = head.pc + XLEN'(4);
  assign op           = head.word[6:0];

  // Next-state for PC and counters; a redirect overrides sequential fetch and empties the buffer
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    if (grant) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (grant && !rsp_take) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!grant && rsp_take) begin
      outstanding_d = outstanding_q - CW'(1);
    end
    if (iq_wr && !iq_pop) begin
      count_d = count_q + CW'(1);
    end else if (!iq_wr && iq_pop) begin
      count_d = count_q - CW'(1);
    end
    if (rsp_take && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (redirect_valid) begin
      // Everything still in flight is stale except a response landing this very cycle,
      // which is dropped here and so is not counted again.
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      discard_d  = outstanding_q - (rsp_take ? CW'(1) : CW'(0));
      count_d    = '0;
    end
  end

  // Register PC, counters and queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      discard_q     <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      pq_wr_ptr_q   <= '0;
      pq_rd_ptr_q   <= '0;
      ib_wr_ptr_q   <= '0;
      ib_rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      discard_q     <= discard_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      if (grant) begin
        pq_wr_ptr_q <= pq_wr_ptr_q + AW'(1);
      end
      if (rsp_take) begin
        pq_rd_ptr_q <= pq_rd_ptr_q + AW'(1);
      end
      if (redirect_valid) begin
        ib_wr_ptr_q <= '0;
        ib_rd_ptr_q <= '0;
      end else begin
        if (iq_wr) begin
          ib_wr_ptr_q <= ib_wr_ptr_q + AW'(1);
        end
        if (iq_pop) begin
          ib_rd_ptr_q <= ib_rd_ptr_q + AW'(1);
        end
      end
    end
  end

  // Queue storage; cleared on reset so the head reads zero until the first instruction lands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcq_q[i]  <= '0;
        ibuf_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        pcq_q[pq_wr_ptr_q] <= fetch_pc_q;
      end
      if (iq_wr) begin
        ibuf_q[ib_wr_ptr_q] <= '{word: imem_rdata, pc: pcq_q[pq_rd_ptr_q]};
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against an in-order instruction memory model.
// Latency: memory answers each grant a configurable number of cycles later.
// Backpressure: decode readiness and memory grant are driven per step.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;
  logic [6:0]  op;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;
  bit mem_on = 1'b1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] popped[$];

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pcplus4   (inst_pcplus4),
    .op             (op)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00B5_0533 ^ {a[23:0], 8'h00};
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (i < popped.size()) return popped[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe this cycle's handshakes, advance one clock, then drive the memory response.
  task automatic cycle();
    logic [31:0] w;
    pend_t       p;
    #1;
    if (dut.iq_wr) chk1("ibuf_wr_not_full", dut.count_q == 2'(DEPTH), 1'b0);
    if (!reset && imem_req && imem_gnt) begin
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
    if (!reset && inst_valid && inst_ready) begin
      popped.push_back(inst_pc);
      w = mem_word(inst_pc);
      chk32("pop_inst_word", inst, w);
      chk32("pop_op", {25'd0, op}, {25'd0, w[6:0]});
      chk32("pop_pcplus4", inst_pcplus4, inst_pc + 32'd4);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_on && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      pend.delete(0);
    end
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b1;
    inst_ready     = 1'b1;
    mem_on         = 1'b1;
    repeat (n) cycle();
    pend.delete();
    popped.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    reset       = 1'b0;
    cyc         = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset state
    repeat (2) cycle();
    #1;
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk32("rst_op", {25'd0, op}, 32'h0);
    pend.delete(); reset = 1'b0; cyc = 0;

    // Zero-wait memory streaming: credits allow two fetches then wait for a slot
    #1; chk1("s1_c0_req", imem_req, 1'b1); chk32("s1_c0_addr", imem_addr, 32'h0);
        chk1("s1_c0_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s1_c1_req", imem_req, 1'b1); chk32("s1_c1_addr", imem_addr, 32'h4);
        chk1("s1_c1_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s1_c2_valid", inst_valid, 1'b1); chk32("s1_c2_pc", inst_pc, 32'h0);
        chk32("s1_c2_inst", inst, 32'h00B5_0533); chk32("s1_c2_op", {25'd0, op}, {25'd0, 7'b0110011});
        chk32("s1_c2_pc4", inst_pcplus4, 32'h4); chk1("s1_c2_req_credit", imem_req, 1'b0);
    cycle(); #1; chk1("s1_c3_req", imem_req, 1'b1); chk32("s1_c3_addr", imem_addr, 32'h8);
        chk32("s1_c3_pc", inst_pc, 32'h4);
    cycle(); #1; chk1("s1_c4_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s1_c5_valid", inst_valid, 1'b1); chk32("s1_c5_pc", inst_pc, 32'h8);
    cycle();

    // Decode stalled for 10 cycles: buffer fills to DEPTH, fetch stops, head holds
    do_reset(1);
    inst_ready = 1'b0;
    repeat (9) cycle();
    #1; chk1("s2_full_req", imem_req, 1'b0); chk1("s2_full_valid", inst_valid, 1'b1);
        chk32("s2_full_pc", inst_pc, 32'h0); chk32("s2_full_count", {30'd0, dut.count_q}, 32'd2);
    cycle();
    inst_ready = 1'b1;
    repeat (4) cycle();
    chk32("s2_pop_n", popped.size(), 32'd3);
    chk32("s2_pop0", pop_at(0), 32'h0);
    chk32("s2_pop1", pop_at(1), 32'h4);
    chk32("s2_pop2", pop_at(2), 32'h8);

    // Grant withheld for 3 cycles: address held, fetch PC not advanced
    do_reset(1);
    imem_gnt = 1'b0;
    #1; chk32("s3_c0_addr", imem_addr, 32'h0);
    cycle(); #1; chk32("s3_c1_addr", imem_addr, 32'h0);
    cycle(); #1; chk32("s3_c2_addr", imem_addr, 32'h0); chk1("s3_c2_req", imem_req, 1'b1);
    cycle(); imem_gnt = 1'b1;
    #1; chk32("s3_c3_addr", imem_addr, 32'h0);
    cycle(); #1; chk32("s3_c4_addr", imem_addr, 32'h4);
    cycle(); #1; chk1("s3_c5_valid", inst_valid, 1'b1); chk32("s3_c5_pc", inst_pc, 32'h0);
    cycle(); #1; chk1("s3_c6_valid", inst_valid, 1'b1); chk32("s3_c6_pc", inst_pc, 32'h4);
    cycle();

    // 3-cycle memory, two requests in flight, redirect to 0x100 drops both
    lat = 3;
    do_reset(1);
    cycle(); #1; chk32("s4_c1_addr", imem_addr, 32'h4);
    cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1; chk1("s4_c2_req_redirect", imem_req, 1'b0);
    cycle(); redirect_valid = 1'b0;
    #1; chk1("s4_c3_req", imem_req, 1'b0); chk1("s4_c3_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s4_c4_req", imem_req, 1'b1); chk32("s4_c4_addr", imem_addr, 32'h100);
        chk1("s4_c4_valid", inst_valid, 1'b0);
    cycle(); #1; chk32("s4_c5_addr", imem_addr, 32'h104); chk1("s4_c5_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s4_c6_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s4_c7_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s4_c8_valid", inst_valid, 1'b1); chk32("s4_c8_pc", inst_pc, 32'h100);
        chk32("s4_c8_inst", inst, 32'h00B4_0533);
    cycle(); #1; chk32("s4_c9_pc", inst_pc, 32'h104);
    cycle();
    chk32("s4_pop_n", popped.size(), 32'd2);
    chk32("s4_pop0", pop_at(0), 32'h100);

    // Redirect coinciding with rvalid and a pop, misaligned target 0x203
    lat = 1;
    do_reset(1);
    cycle(); cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #1; chk1("s5_c2_valid", inst_valid, 1'b1); chk1("s5_c2_rvalid", imem_rvalid, 1'b1);
    cycle(); redirect_valid = 1'b0;
    #1; chk1("s5_c3_req", imem_req, 1'b1); chk32("s5_c3_addr", imem_addr, 32'h200);
        chk1("s5_c3_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s5_c4_valid", inst_valid, 1'b0);
    cycle(); #1; chk1("s5_c5_valid", inst_valid, 1'b1); chk32("s5_c5_pc", inst_pc, 32'h200);
    cycle();
    chk32("s5_pop_n", popped.size(), 32'd2);
    chk32("s5_pop0", pop_at(0), 32'h0);
    chk32("s5_pop1", pop_at(1), 32'h200);

    // Back-to-back redirects: the last target wins
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'h44;
    #1; chk1("s6_c0_req", imem_req, 1'b0);
    cycle(); redirect_pc = 32'h81;
    #1; chk1("s6_c1_req", imem_req, 1'b0);
    cycle(); redirect_valid = 1'b0;
    #1; chk1("s6_c2_req", imem_req, 1'b1); chk32("s6_c2_addr", imem_addr, 32'h80);
    cycle(); cycle();
    #1; chk1("s6_c4_valid", inst_valid, 1'b1); chk32("s6_c4_pc", inst_pc, 32'h80);
    cycle();

    // Reset with credits exhausted, then a late response after release
    lat = 3;
    do_reset(1);
    inst_ready = 1'b0;
    repeat (3) cycle();
    #1; chk1("s7_c3_valid", inst_valid, 1'b0);
    mem_on = 1'b0;
    cycle();
    #1; chk1("s7_c4_valid", inst_valid, 1'b1); chk32("s7_c4_pc", inst_pc, 32'h0);
        chk32("s7_c4_out", {30'd0, dut.outstanding_q}, 32'd1);
    reset = 1'b1;
    #1; chk1("s7_c4_req_rst", imem_req, 1'b0);
    cycle();
    #1; chk1("s7_c5_valid", inst_valid, 1'b0); chk1("s7_c5_req", imem_req, 1'b0);
        chk32("s7_c5_pc", inst_pc, 32'h0);
    cycle();
    pend.delete(); popped.delete();
    reset = 1'b0; cyc = 0; lat = 1; mem_on = 1'b1; inst_ready = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h4);
    #1; chk1("s7_restart_req", imem_req, 1'b1); chk32("s7_restart_addr", imem_addr, 32'h0);
    cycle(); #1; chk1("s7_stray_ignored", inst_valid, 1'b0);
    cycle(); #1; chk1("s7_first_valid", inst_valid, 1'b1); chk32("s7_first_pc", inst_pc, 32'h0);
        chk32("s7_first_inst", inst, 32'h00B5_0533);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
